// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches to the I-cache and queues {instr, pc} toward decode.
// Define FETCH_PERF_EN to build the fetched-instruction and stall-cycle performance counters.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FQ_DEPTH   = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h0000_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] ic_addr,
    output logic                  ic_req,
    input  logic [DATA_WIDTH-1:0] ic_data,
    input  logic                  ic_valid,
    input  logic                  ic_stall,
    output logic                  ic_invalidate,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  fence_i,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0] if_pc,
    input  logic                  if_ready,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_stall_cycles
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(FQ_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] fq_instr [FQ_DEPTH];
    logic [ADDR_WIDTH-1:0] fq_pc    [FQ_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  drop;
    logic                  pop;
    logic                  push;

    assign if_valid      = (count != '0);
    assign if_instr      = fq_instr[rd_ptr];
    assign if_pc         = fq_pc[rd_ptr];
    assign pop           = if_valid && if_ready;
    assign ic_req        = !redirect_valid && ((count < FULL_COUNT) || pop);
    assign ic_addr       = pc;
    assign push          = ic_req && ic_valid && !drop && !redirect_valid;
    assign ic_invalidate = redirect_valid && fence_i;

    // The PC only advances when its word is actually queued, so it stays put across a miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ALIGN_MASK;
        end else if (push) begin
            pc <= pc + ADDR_WIDTH'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_instr[i] <= '0;
                fq_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fq_instr[wr_ptr] <= ic_data;
                fq_pc[wr_ptr]    <= pc;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // A redirect during a refill leaves one stale word still to come back; FENCE.I aborts the refill instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop <= 1'b0;
        end else if (redirect_valid) begin
            if (fence_i) begin
                drop <= 1'b0;
            end else if (ic_stall) begin
                drop <= 1'b1;
            end else if (ic_valid) begin
                drop <= 1'b0;
            end
        end else if (drop && ic_valid) begin
            drop <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (push) begin
                fetched_cnt <= fetched_cnt + 32'd1;
            end
            if (ic_stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign perf_fetched      = fetched_cnt;
    assign perf_stall_cycles = stall_cnt;
`else
    assign perf_fetched      = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule
